turn_switch_n: RTL and testbench

//  N-player turn controller for the chess-clock datapath; generalises the 2-player enable switch.

---
 rtl/turn_pkg.sv | 21 ++
 rtl/turn_switch_n_press_edge.sv | 25 ++
 rtl/turn_switch_n.sv | 126 ++++++++++++
 tb/tb_turn_switch_n.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/turn_pkg.sv
// Shared definitions for the N-player turn controller: state encoding and index-width helper.
package turn_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

   // Width of a player index; never below one bit so a 1-bit ACTIVE exists for two players.
   function automatic int idx_w(input int n);
      if (n <= 2)
         return 1;
      else
         return $clog2(n);
   endfunction

endpackage

// File: rtl/turn_switch_n_press_edge.sv
// press_edge: N-wide rising-edge detector on the player buttons, history sampled only on CE ticks
// so that a button held across several ticks produces exactly one edge.
module press_edge #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         ce,
   input  logic [W-1:0] press,
   output logic [W-1:0] rise
);

   logic [W-1:0] press_q;

   // Button history register, advanced at the sampling tick rate only.
   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         press_q <= '0;
      else if (ce)
         press_q <= press;
   end

   assign rise = press & ~press_q;

endmodule

// File: rtl/turn_switch_n.sv
// turn_switch_n: N-player chess-clock turn controller driving one-hot timer enables.
// Optional feature macro: TURN_BONUS_EN (Fischer increment pulse on BONUS for the player who just moved).
module turn_switch_n
   import turn_pkg::*;
#(
   parameter int N_PLAYERS    = 2,
   parameter int FIRST_PLAYER = 0,
   parameter int CNT_W        = 10,
   localparam int IDX_W       = idx_w(N_PLAYERS)
) (
   input  logic                 CLK,
   input  logic                 CLR,
   input  logic                 CE,
   input  logic                 START,
   input  logic                 STOP,
   input  logic                 END,
   input  logic [N_PLAYERS-1:0] PRESS,
   output logic [N_PLAYERS-1:0] ENABLE,
   output logic [IDX_W-1:0]     ACTIVE,
   output logic [STATE_W-1:0]   STATE,
   output logic [CNT_W-1:0]     MOVE_CNT,
   output logic [N_PLAYERS-1:0] BONUS
);

   localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_PLAYER);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_PLAYERS - 1);

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       active, active_nxt;
   logic [CNT_W-1:0]       move_cnt, cnt_nxt;
   logic [N_PLAYERS-1:0]   enable, enable_nxt;
   logic [N_PLAYERS-1:0]   press_rise;
   logic                   pass;

   press_edge #(
      .W (N_PLAYERS)
   ) u_press_edge (
      .clk   (CLK),
      .clr   (CLR),
      .ce    (CE),
      .press (PRESS),
      .rise  (press_rise)
   );

   // Next-state, turn pass and next one-hot enable; END beats STOP beats a press while running.
   always_comb begin
      state_nxt  = state;
      active_nxt = active;
      pass       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) begin
               state_nxt  = ST_RUN;
               active_nxt = FIRST_IDX;
            end
         end
         ST_RUN: begin
            if (END)
               state_nxt = ST_DONE;
            else if (STOP)
               state_nxt = ST_PAUSE;
            else if (press_rise[active]) begin
               pass       = 1'b1;
               active_nxt = (active == LAST_IDX) ? '0 : active + 1'b1;
            end
         end
         ST_PAUSE: begin
            if (END)
               state_nxt = ST_DONE;
            else if (!STOP)
               state_nxt = ST_RUN;
         end
         ST_DONE: begin
            state_nxt = ST_DONE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      cnt_nxt = (pass && (move_cnt != '1)) ? move_cnt + 1'b1 : move_cnt;

      for (int i = 0; i < N_PLAYERS; i++)
         enable_nxt[i] = (state_nxt == ST_RUN) && (active_nxt == IDX_W'(i));
   end

   // Controller registers; the enable decode is registered alongside the state so both move together.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state    <= ST_IDLE;
         active   <= FIRST_IDX;
         move_cnt <= '0;
         enable   <= '0;
      end else if (CE) begin
         state    <= state_nxt;
         active   <= active_nxt;
         move_cnt <= cnt_nxt;
         enable   <= enable_nxt;
      end
   end

`ifdef TURN_BONUS_EN
   logic [N_PLAYERS-1:0] bonus;

   // One-clock increment pulse to the player who just handed over the turn; cleared on every other clock.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR)
         bonus <= '0;
      else begin
         bonus <= '0;
         if (CE && pass)
            bonus[active] <= 1'b1;
      end
   end

   assign BONUS = bonus;
`else
   assign BONUS = '0;
`endif

   assign ENABLE   = enable;
   assign ACTIVE   = active;
   assign STATE    = state;
   assign MOVE_CNT = move_cnt;

endmodule

// File: tb/tb_turn_switch_n.sv
// Testbench for turn_switch_n: three players, 2-bit move counter, table-driven vectors plus
// hand-written asynchronous-reset sequences. Expected BONUS follows the TURN_BONUS_EN macro.
module tb_turn_switch_n;

   localparam int N  = 3;
   localparam int CW = 2;
   localparam int IW = 2;

   typedef struct {
      string       name;
      logic        ce;
      logic        start;
      logic        stop;
      logic        endg;
      logic [N-1:0] press;
      logic [1:0]  e_state;
      logic [N-1:0] e_enable;
      logic [IW-1:0] e_active;
      logic [CW-1:0] e_cnt;
      logic [N-1:0] e_bonus;
   } vec_t;

   logic          CLK;
   logic          CLR;
   logic          CE;
   logic          START;
   logic          STOP;
   logic          END;
   logic [N-1:0]  PRESS;
   logic [N-1:0]  ENABLE;
   logic [IW-1:0] ACTIVE;
   logic [1:0]    STATE;
   logic [CW-1:0] MOVE_CNT;
   logic [N-1:0]  BONUS;

   int tests_run;
   int tests_failed;
   vec_t vecs1[$];
   vec_t vecs2[$];

   turn_switch_n #(
      .N_PLAYERS    (N),
      .FIRST_PLAYER (0),
      .CNT_W        (CW)
   ) dut (
      .CLK      (CLK),
      .CLR      (CLR),
      .CE       (CE),
      .START    (START),
      .STOP     (STOP),
      .END      (END),
      .PRESS    (PRESS),
      .ENABLE   (ENABLE),
      .ACTIVE   (ACTIVE),
      .STATE    (STATE),
      .MOVE_CNT (MOVE_CNT),
      .BONUS    (BONUS)
   );

   // Free-running 10-time-unit clock.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic vec_t mk(input string n, input logic ce, input logic st, input logic sp,
                               input logic en, input logic [N-1:0] pr, input logic [1:0] s,
                               input logic [N-1:0] e, input logic [IW-1:0] a,
                               input logic [CW-1:0] c, input logic [N-1:0] b);
      vec_t v;
      v.name = n; v.ce = ce; v.start = st; v.stop = sp; v.endg = en; v.press = pr;
      v.e_state = s; v.e_enable = e; v.e_active = a; v.e_cnt = c; v.e_bonus = b;
      return v;
   endfunction

   task automatic compareField(input string name, input int act, input int exp);
      tests_run++;
      if (act != exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input logic [1:0] s, input logic [N-1:0] e,
                              input logic [IW-1:0] a, input logic [CW-1:0] c,
                              input logic [N-1:0] b);
      logic [N-1:0] exp_bonus;
`ifdef TURN_BONUS_EN
      exp_bonus = b;
`else
      exp_bonus = '0;
`endif
      compareField({name, " STATE"},    int'(STATE),    int'(s));
      compareField({name, " ENABLE"},   int'(ENABLE),   int'(e));
      compareField({name, " ACTIVE"},   int'(ACTIVE),   int'(a));
      compareField({name, " MOVE_CNT"}, int'(MOVE_CNT), int'(c));
      compareField({name, " BONUS"},    int'(BONUS),    int'(exp_bonus));
   endtask

   task automatic applyStimulus(input vec_t v);
      @(negedge CLK);
      CE    = v.ce;
      START = v.start;
      STOP  = v.stop;
      END   = v.endg;
      PRESS = v.press;
      @(posedge CLK);
      #1;
      checkOutput(v.name, v.e_state, v.e_enable, v.e_active, v.e_cnt, v.e_bonus);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      CLR   = 1'b1;
      CE    = 1'b0;
      START = 1'b0;
      STOP  = 1'b0;
      END   = 1'b0;
      PRESS = '0;

      //          name         ce st sp en press   state  enable  act    cnt    bonus
      vecs1.push_back(mk("idle_ign", 1, 0, 1, 1, 3'b001, 2'b00, 3'b000, 2'd0, 2'd0, 3'b000));
      vecs1.push_back(mk("start",    1, 1, 0, 0, 3'b000, 2'b01, 3'b001, 2'd0, 2'd0, 3'b000));
      vecs1.push_back(mk("p0_pass",  1, 0, 0, 0, 3'b001, 2'b01, 3'b010, 2'd1, 2'd1, 3'b001));
      vecs1.push_back(mk("rel0",     1, 0, 0, 0, 3'b000, 2'b01, 3'b010, 2'd1, 2'd1, 3'b000));
      vecs1.push_back(mk("p1_pass",  1, 0, 0, 0, 3'b010, 2'b01, 3'b100, 2'd2, 2'd2, 3'b010));
      vecs1.push_back(mk("rel1",     1, 0, 0, 0, 3'b000, 2'b01, 3'b100, 2'd2, 2'd2, 3'b000));
      vecs1.push_back(mk("p2_wrap",  1, 0, 0, 0, 3'b100, 2'b01, 3'b001, 2'd0, 2'd3, 3'b100));
      vecs1.push_back(mk("rel2",     1, 0, 0, 0, 3'b000, 2'b01, 3'b001, 2'd0, 2'd3, 3'b000));
      vecs1.push_back(mk("sat_p0",   1, 0, 0, 0, 3'b001, 2'b01, 3'b010, 2'd1, 2'd3, 3'b001));
      vecs1.push_back(mk("rel3",     1, 0, 0, 0, 3'b000, 2'b01, 3'b010, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("nonact",   1, 0, 0, 0, 3'b101, 2'b01, 3'b010, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("rel4",     1, 0, 0, 0, 3'b000, 2'b01, 3'b010, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("hold_p1",  1, 0, 0, 0, 3'b010, 2'b01, 3'b100, 2'd2, 2'd3, 3'b010));
      vecs1.push_back(mk("held_p1",  1, 0, 0, 0, 3'b010, 2'b01, 3'b100, 2'd2, 2'd3, 3'b000));
      vecs1.push_back(mk("rel5",     1, 0, 0, 0, 3'b000, 2'b01, 3'b100, 2'd2, 2'd3, 3'b000));
      vecs1.push_back(mk("sat_p2",   1, 0, 0, 0, 3'b100, 2'b01, 3'b001, 2'd0, 2'd3, 3'b100));
      vecs1.push_back(mk("rel6",     1, 0, 0, 0, 3'b000, 2'b01, 3'b001, 2'd0, 2'd3, 3'b000));
      vecs1.push_back(mk("to_p1",    1, 0, 0, 0, 3'b001, 2'b01, 3'b010, 2'd1, 2'd3, 3'b001));
      vecs1.push_back(mk("rel7",     1, 0, 0, 0, 3'b000, 2'b01, 3'b010, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("pause",    1, 0, 1, 0, 3'b000, 2'b10, 3'b000, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("pause_pr", 1, 0, 1, 0, 3'b010, 2'b10, 3'b000, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("resume",   1, 0, 0, 0, 3'b010, 2'b01, 3'b010, 2'd1, 2'd3, 3'b000));
      vecs1.push_back(mk("hist_kept",1, 0, 0, 0, 3'b010, 2'b01, 3'b010, 2'd1, 2'd3, 3'b000));

      vecs2.push_back(mk("start2",   1, 1, 0, 0, 3'b000, 2'b01, 3'b001, 2'd0, 2'd0, 3'b000));
      vecs2.push_back(mk("p0_b",     1, 0, 0, 0, 3'b001, 2'b01, 3'b010, 2'd1, 2'd1, 3'b001));
      vecs2.push_back(mk("rel_b",    1, 0, 0, 0, 3'b000, 2'b01, 3'b010, 2'd1, 2'd1, 3'b000));
      vecs2.push_back(mk("ce0_pr",   0, 0, 0, 0, 3'b010, 2'b01, 3'b010, 2'd1, 2'd1, 3'b000));
      vecs2.push_back(mk("ce1_pr",   1, 0, 0, 0, 3'b010, 2'b01, 3'b100, 2'd2, 2'd2, 3'b010));
      vecs2.push_back(mk("rel_c",    1, 0, 0, 0, 3'b000, 2'b01, 3'b100, 2'd2, 2'd2, 3'b000));
      vecs2.push_back(mk("priority", 1, 0, 1, 1, 3'b100, 2'b11, 3'b000, 2'd2, 2'd2, 3'b000));
      vecs2.push_back(mk("done_st",  1, 1, 0, 0, 3'b000, 2'b11, 3'b000, 2'd2, 2'd2, 3'b000));
      vecs2.push_back(mk("done_pr",  1, 0, 0, 0, 3'b100, 2'b11, 3'b000, 2'd2, 2'd2, 3'b000));

      repeat (2) @(negedge CLK);
      CLR = 1'b0;
      #1;
      checkOutput("reset", 2'b00, 3'b000, 2'd0, 2'd0, 3'b000);

      foreach (vecs1[i]) applyStimulus(vecs1[i]);

      // Asynchronous clear mid-game: outputs must drop before any clock edge.
      @(negedge CLK);
      PRESS = '0;
      #2;
      CLR = 1'b1;
      #1;
      checkOutput("clr_async", 2'b00, 3'b000, 2'd0, 2'd0, 3'b000);
      @(negedge CLK);
      CLR = 1'b0;

      foreach (vecs2[i]) applyStimulus(vecs2[i]);

      // Clear while a bonus pulse would be live: nothing survives the clear.
      @(negedge CLK);
      CLR = 1'b1;
      #1;
      checkOutput("clr_done", 2'b00, 3'b000, 2'd0, 2'd0, 3'b000);
      CLR = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("idle_hold", 2'b00, 3'b000, 2'd0, 2'd0, 3'b000);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
